// File: rtl/arbitro_memoria_tabuleiro.sv
// Arbiter/sequencer for the two player board RAMs shared by VGA, colisor, validador and pontuacao.
// Optional feature macro: ARBITRO_RMW_EN (colisor writes become atomic read-modify-write clears).
module arbitro_memoria_tabuleiro #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ROWS   = 11
) (
    input  logic                  clk,
    input  logic                  resetGeral,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [3:0]            jog,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]     mem_q_p1,
    input  logic [DATA_W-1:0]     mem_q_p2,
    output logic [3:0]            gnt,
    output logic [3:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  wrenP1,
    output logic                  wrenP2
);
`ifdef ARBITRO_RMW_EN
    localparam bit RmwEn = 1'b1;
`else
    localparam bit RmwEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;

    state_t              state_q, state_d;
    logic                skip_q, skip_d;
    logic [1:0]          rr_q, rr_d;
    logic [1:0]          idx_q, idx_d;
    logic                jog_q, jog_d;
    logic                rmw_q, rmw_d;
    logic                oor_q, oor_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [3:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                wren1_q, wren1_d;
    logic                wren2_q, wren2_d;

    logic                win_valid;
    logic [1:0]          win_idx;
    int unsigned         cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic [DATA_W-1:0]   row;

    // VGA has priority except right after its own grant; 1..3 rotate from rr_q.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 0;
        if (req[0] && !(skip_q && (|req[3:1]))) begin
            win_valid = 1'b1;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                cand = (32'(rr_q) + k) % 32'd3 + 32'd1;
                if (!win_valid && req[cand[1:0]]) begin
                    win_valid = 1'b1;
                    win_idx   = cand[1:0];
                end
            end
        end
    end

    always_comb begin
        sel_addr  = addr[win_idx*ADDR_W +: ADDR_W];
        sel_wdata = wdata[win_idx*DATA_W +: DATA_W];
        sel_we    = we[win_idx] && ((win_idx == 2'd1) || (win_idx == 2'd2));
        row       = jog_q ? mem_q_p2 : mem_q_p1;

        state_d    = state_q;
        skip_d     = skip_q;
        rr_d       = rr_q;
        idx_d      = idx_q;
        jog_d      = jog_q;
        rmw_d      = rmw_q;
        oor_d      = oor_q;
        mask_d     = mask_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata_d    = '0;
        err_d      = 1'b0;
        wren1_d    = 1'b0;
        wren2_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    gnt_d      = 4'b0001 << win_idx;
                    idx_d      = win_idx;
                    jog_d      = jog[win_idx];
                    mask_d     = sel_wdata;
                    rmw_d      = RmwEn && (win_idx == 2'd1) && we[1];
                    oor_d      = 32'(sel_addr) >= ROWS;
                    mem_addr_d = sel_addr;
                    mem_data_d = sel_wdata;
                    skip_d     = (win_idx == 2'd0);
                    if (win_idx != 2'd0) begin
                        rr_d = (win_idx == 2'd3) ? 2'd0 : win_idx;
                    end
                    if (oor_d) begin
                        state_d = WR;
                    end else if (sel_we && !rmw_d) begin
                        state_d = WR;
                        wren1_d = !jog[win_idx];
                        wren2_d = jog[win_idx];
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = RSP;
            RSP: begin
                rdata_d  = row;
                rvalid_d = 4'b0001 << idx_q;
                if (RmwEn && rmw_q) begin
                    mem_data_d = row & ~mask_q;
                    wren1_d    = !jog_q;
                    wren2_d    = jog_q;
                    state_d    = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                // An RMW already reported completion from RSP with the original row.
                if (!rmw_q) begin
                    rvalid_d = 4'b0001 << idx_q;
                    err_d    = oor_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            state_q    <= IDLE;
            skip_q     <= 1'b0;
            rr_q       <= '0;
            idx_q      <= '0;
            jog_q      <= 1'b0;
            rmw_q      <= 1'b0;
            oor_q      <= 1'b0;
            mask_q     <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wren1_q    <= 1'b0;
            wren2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            jog_q      <= jog_d;
            rmw_q      <= rmw_d;
            oor_q      <= oor_d;
            mask_q     <= mask_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            wren1_q    <= wren1_d;
            wren2_q    <= wren2_d;
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign wrenP1   = wren1_q;
    assign wrenP2   = wren2_q;

endmodule

// File: tb/tb_arbitro_memoria_tabuleiro.sv
// Scoreboard bench for arbitro_memoria_tabuleiro: grant order, response data/latency, RAM writes.
module tb_arbitro_memoria_tabuleiro;
    localparam int AW = 5;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            resetGeral;
    logic [3:0]      req, we, jog;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [DW-1:0]   mem_q_p1, mem_q_p2;
    logic [3:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, mem_data;
    logic            err, wrenP1, wrenP2;
    logic [AW-1:0]   mem_addr;

    arbitro_memoria_tabuleiro #(.ADDR_W(AW), .DATA_W(DW), .ROWS(11)) dut (
        .clk(clk), .resetGeral(resetGeral), .req(req), .we(we), .jog(jog),
        .addr(addr), .wdata(wdata), .mem_q_p1(mem_q_p1), .mem_q_p2(mem_q_p2),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_data(mem_data), .wrenP1(wrenP1), .wrenP2(wrenP2)
    );

    always #5 clk = ~clk;

    // Registered-address board RAMs, preloaded once.
    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] mem2 [32];
    logic [AW-1:0] ra_q = '0;
    logic          preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] <= '0;
                mem2[i] <= '0;
            end
            mem1[1] <= 64'h11; mem1[2] <= 64'h22; mem1[3] <= 64'h00F0;
            mem1[4] <= 64'h44; mem1[5] <= 64'hFF;
            preloaded <= 1'b1;
        end else begin
            if (wrenP1) mem1[mem_addr] <= mem_data;
            if (wrenP2) mem2[mem_addr] <= mem_data;
        end
        ra_q <= mem_addr;
    end
    assign mem_q_p1 = mem1[ra_q];
    assign mem_q_p2 = mem2[ra_q];

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } rsp_t;

    int   exp_gnt[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   gcyc[4];
    int   seq[8] = '{0, 1, 0, 2, 0, 3, 0, 1};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents gnt or rvalid.
    always @(negedge clk) begin
        if (!resetGeral) begin
            if (wrenP1 && wrenP2) chk("wren_exclusive", 64'(1), 64'(0));
            if (gnt != 4'b0) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'(0));
                else begin
                    automatic int g = exp_gnt.pop_front();
                    chk("gnt_order", 64'(gnt), 64'(4'b0001 << g));
                    gcyc[g] = cyc;
                end
            end
            if (rvalid != 4'b0) begin
                if (exp_rsp.size() == 0) chk("rvalid_unexpected", 64'(rvalid), 64'(0));
                else begin
                    automatic rsp_t r = exp_rsp.pop_front();
                    chk("rvalid_onehot", 64'(rvalid), 64'(4'b0001 << r.idx));
                    chk("rdata", rdata, r.data);
                    chk("err", 64'(err), 64'(r.err));
                    chk("rsp_latency", 64'(cyc - gcyc[r.idx]), 64'(r.lat));
                end
            end
        end
    end

    task automatic set_slot(input int i, input logic w, input logic j,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i] = w;
        jog[i] = j;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic push_rsp(input int i, input logic [DW-1:0] d, input logic e, input int l);
        rsp_t r;
        r.idx = i; r.data = d; r.err = e; r.lat = l;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_gnt(input int i);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt[i]) return;
        end
        chk("gnt_timeout", 64'(i), 64'(99));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        req = '0; we = '0; jog = '0; addr = '0; wdata = '0;
        resetGeral = 1'b1;
        idle(3);
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rdata", rdata, 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_data", mem_data, 64'(0));
        chk("rst_wren", 64'({wrenP1, wrenP2}), 64'(0));
        resetGeral = 1'b0;
        idle(2);

        // VGA read, jogador 1 row 3
        exp_gnt.push_back(0);
        push_rsp(0, 64'h00F0, 1'b0, 2);
        set_slot(0, 1'b0, 1'b0, 5'd3, '0);
        req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        chk("vga_mem_addr", 64'(mem_addr), 64'(3));
        chk("vga_no_wren", 64'({wrenP1, wrenP2}), 64'(0));
        idle(1);
        chk("vga_no_wren2", 64'({wrenP1, wrenP2}), 64'(0));
        idle(3);

        // Validador write, jogador 2 row 10
        exp_gnt.push_back(2);
        push_rsp(2, 64'(0), 1'b0, 1);
        set_slot(2, 1'b1, 1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
        req[2] = 1'b1;
        wait_gnt(2);
        req[2] = 1'b0;
        chk("val_wrenP2", 64'({wrenP1, wrenP2}), 64'(1));
        chk("val_mem_addr", 64'(mem_addr), 64'(10));
        idle(1);
        chk("val_wren_one_cycle", 64'({wrenP1, wrenP2}), 64'(0));
        chk("val_row10", mem2[10], 64'hFFFF_FFFF_FFFF_FFFF);
        idle(3);

        // Colisor on jogador 1 row 5, mask 0x01; validador read pending behind it
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
`ifdef ARBITRO_RMW_EN
        push_rsp(1, 64'hFF, 1'b0, 2);
`else
        push_rsp(1, 64'(0), 1'b0, 1);
`endif
        push_rsp(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
        set_slot(1, 1'b1, 1'b0, 5'd5, 64'h01);
        set_slot(2, 1'b0, 1'b1, 5'd10, '0);
        req[1] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        req[2] = 1'b1;
        wait_gnt(2);
        req[2] = 1'b0;
`ifdef ARBITRO_RMW_EN
        chk("rmw_row5", mem1[5], 64'hFE);
`else
        chk("plainwr_row5", mem1[5], 64'h01);
`endif
        idle(4);

        // Pontuacao read of out-of-range row 11
        exp_gnt.push_back(3);
        push_rsp(3, 64'(0), 1'b1, 1);
        set_slot(3, 1'b0, 1'b0, 5'd11, '0);
        req[3] = 1'b1;
        wait_gnt(3);
        req[3] = 1'b0;
        chk("oor_no_wren", 64'({wrenP1, wrenP2}), 64'(0));
        idle(1);
        chk("oor_no_wren2", 64'({wrenP1, wrenP2}), 64'(0));
        idle(3);

        // Reset during a validador write; afterwards colisor beats pontuacao
        exp_gnt.push_back(2);
        set_slot(2, 1'b1, 1'b1, 5'd7, 64'hDEAD);
        req[2] = 1'b1;
        wait_gnt(2);
        req[2] = 1'b0;
        chk("abort_wren_before", 64'({wrenP1, wrenP2}), 64'(1));
        #2 resetGeral = 1'b1;
        #1;
        chk("abort_wren_async", 64'({wrenP1, wrenP2}), 64'(0));
        chk("abort_no_rvalid", 64'(rvalid), 64'(0));
        idle(2);
        resetGeral = 1'b0;
        chk("abort_row7", mem2[7], 64'(0));
        exp_gnt.push_back(1);
        exp_gnt.push_back(3);
        push_rsp(1, 64'h11, 1'b0, 2);
        push_rsp(3, 64'h44, 1'b0, 2);
        set_slot(1, 1'b0, 1'b0, 5'd1, '0);
        set_slot(3, 1'b0, 1'b0, 5'd4, '0);
        req[1] = 1'b1;
        req[3] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        wait_gnt(3);
        req[3] = 1'b0;
        idle(4);

        // Fresh reset, all four requesting continuously
        resetGeral = 1'b1;
        idle(2);
        resetGeral = 1'b0;
        idle(1);
        set_slot(0, 1'b0, 1'b0, 5'd3, '0);
        set_slot(1, 1'b0, 1'b0, 5'd1, '0);
        set_slot(2, 1'b0, 1'b0, 5'd2, '0);
        set_slot(3, 1'b0, 1'b0, 5'd4, '0);
        for (int k = 0; k < 8; k++) begin
            exp_gnt.push_back(seq[k]);
            case (seq[k])
                0: push_rsp(0, 64'h00F0, 1'b0, 2);
                1: push_rsp(1, 64'h11, 1'b0, 2);
                2: push_rsp(2, 64'h22, 1'b0, 2);
                default: push_rsp(3, 64'h44, 1'b0, 2);
            endcase
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) wait_gnt(seq[k]);
        req = 4'b0000;

        for (int n = 0; n < 20 && (exp_rsp.size() != 0 || exp_gnt.size() != 0); n++) idle(1);
        idle(2);
        chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'(0));
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/arbitro_memoria_tabuleiro.md
# arbitro_memoria_tabuleiro

Arbiter and sequencer sitting between the two player board RAMs (jogador 1 / jogador 2, one row of `DATA_W` bits per board line) and the four blocks that share them: VGA, colisor, validador and pontuação. It grants exactly one requester per transaction and drives the single shared address/data/write-enable bus to both RAMs. It also returns read data to the granted requester, and for the colisor it can run an atomic read-modify-write that clears hit bits in a row.

## Interface
Parameters:
- `ADDR_W`, 5, row address width
- `DATA_W`, 64, row width
- `ROWS`, 11, valid rows; addresses ≥ ROWS are out of range

Requester index: 0 = VGA, 1 = colisor, 2 = validador, 3 = pontuação.

Ports:
- `clk`  in  1  sole clock, rising edge
- `resetGeral`  in  1  asynchronous, active-high reset
- `req`  in  4  per-requester request; held until `gnt`
- `we`  in  4  per-requester write (1) / read (0); `we[0]` and `we[3]` ignored (read-only)
- `jog`  in  4  per-requester target board: 0 = jogador 1, 1 = jogador 2
- `addr`  in  4*ADDR_W  packed row addresses, requester i at `[i*ADDR_W +: ADDR_W]`
- `wdata`  in  4*DATA_W  packed write data; colisor slot is the clear-mask in RMW mode
- `mem_q_p1`, `mem_q_p2`  in  DATA_W each  RAM read data; valid 1 cycle after address (registered-address RAM)
- `gnt`  out  4  one-hot, 1-cycle pulse, request accepted and latched
- `rvalid`  out  4  one-hot, 1-cycle pulse, transaction complete
- `rdata`  out  DATA_W  read data, valid with `rvalid`; 0 for writes and errors
- `err`  out  1  pulses with `rvalid` on an out-of-range address
- `mem_addr`  out  ADDR_W  shared RAM address
- `mem_data`  out  DATA_W  shared RAM write data
- `wrenP1`, `wrenP2`  out  1 each  RAM write enables; never both high

## Operation
- FSM states: IDLE, RD, RSP, WR.
- **IDLE:** if any `req`, choose a winner and latch its `we/jog/addr/wdata`. Pulse its `gnt` next cycle.
  - Out-of-range address or write → WR.
  - Read → RD.
- **RD:** drive `mem_addr`; wren low.
- **RSP:** capture `mem_q_p1`/`mem_q_p2` per latched `jog`.
  - Plain read: register `rdata` and pulse `rvalid` → IDLE.
  - Colisor RMW: → WR.
- **WR:** drive `mem_addr` and `mem_data`, and assert the wren selected by `jog` for exactly one cycle → IDLE. Completion is a `rvalid` pulse, `rdata` = 0.
  - Out-of-range: no wren, `err`=1, `rdata`=0.
- **Arbitration:**
  - VGA wins unless the previous grant was VGA and any of 1..3 is pending. In that case it is skipped for one decision.
  - Requesters 1..3 share a round-robin pointer, advanced past each winner. Reset value: colisor first.
- Requests are not preempted. A `req` dropped before `gnt` is simply not served.
- Reset outputs: `gnt`=0, `rvalid`=0, `rdata`=0, `err`=0, `mem_addr`=0, `mem_data`=0, `wrenP1`=`wrenP2`=0, state IDLE, VGA-skip flag 0.
- Reset mid-transaction aborts it. The wren drops asynchronously and no `rvalid` is issued.

## Timing
- `req` sampled in IDLE at edge t.
- `gnt` and the first access cycle are at t+1.
- Read: `rvalid`/`rdata` at t+3, next arbitration at the t+3 edge. Throughput is 1 read per 3 cycles.
- Write or error: wren at t+1, `rvalid` at t+2.
- RMW: RD t+1, RSP t+2, WR t+3, and `rvalid` with the original row at t+3. New row = old & ~mask.
- All outputs are registered. Nothing is combinational from `req` to any output.

## Configuration
- `ARBITRO_RMW_EN`, defined:
  - A colisor transaction with `we[1]`=1 is atomic read-modify-write.
  - `wdata` slot 1 is the clear-mask.
  - `rdata` returns the pre-write row.
- Not defined:
  - Colisor `we[1]`=1 is a plain write of `wdata` slot 1.
  - The RSP→WR path does not exist.

## Test plan
- After reset, VGA reads jogador 1 row 3 holding `64'h00F0`: `gnt[0]` at t+1, `mem_addr`=3, `rvalid[0]` with `rdata`=`64'h00F0` at t+3; `wrenP1`/`wrenP2` stay 0.
- Validador writes `64'hFFFF_FFFF_FFFF_FFFF` to jogador 2 row 10: `wrenP2`=1 for exactly one cycle at t+1 with `mem_addr`=10; `rvalid[2]` at t+2; `wrenP1` stays 0.
- All four requesters hold `req` continuously: grant order is 0,1,0,2,0,3,0,1…; no requester waits more than 6 grants.
- With RMW enabled, colisor on jogador 1 row 5 = `64'hFF`, mask `64'h01`: `rvalid[1]` with `rdata`=`64'hFF`; row 5 written `64'hFE`; no other grant is issued during the sequence.
- Pontuação reads address 11 (≥ ROWS): `err`=1 and `rvalid[3]` at t+2, `rdata`=0, no wren.
- `resetGeral` asserted during WR of a validador write: wren drops immediately, no `rvalid`, state IDLE; after release the first grant goes to the colisor if it is pending.
